dmem_bridge: RTL and testbench

Data-memory bridge directly downstream of the load/store unit. Accepts one single-cycle request pulse from the load/store unit's RAM port (address, size, write enable, low-aligned write data), converts it into a byte-masked 64-bit word access on a synchronous single-port data RAM, and returns low-aligned read data with a one-cycle ready pulse. Also inserts programmable wait states and reports misaligned and out-of-range accesses without touching memory.

---
 rtl/dmem_bridge.sv | 153 +++++++++++++++
 tb/tb_dmem_bridge.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns single-cycle LSU requests into byte-masked 64-bit RAM word
// accesses with optional wait states and misalign / out-of-range reporting.
//
// state  | meaning
// IDLE   | waiting for a request
// WAIT   | counting down wait states before the RAM access
// ACCESS | RAM strobe cycle
// RESP   | ready pulse, result on o_ram_rdata
module dmem_bridge #(
  parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
  parameter int          ADDR_W  = 20,
  parameter int          LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ram_valid,
  input  logic              i_ram_wen,
  input  logic [63:0]       i_ram_addr,
  input  logic [2:0]        i_ram_size,
  input  logic [63:0]       i_ram_wdata,
  output logic              o_ram_ready,
  output logic [63:0]       o_ram_rdata,
  output logic              o_misalign,
  output logic              o_fault,
  output logic              o_mem_en,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_idx,
  output logic [63:0]       o_mem_wmask,
  output logic [63:0]       o_mem_wdata,
  input  logic [63:0]       i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_wen_q;
  logic [2:0]        req_size_q;
  logic [2:0]        req_off_q;
  logic              mis_q, flt_q;
  logic [63:0]       rdata_q;
  logic [ADDR_W-1:0] mem_idx_q;
  logic [63:0]       wmask_q, wdata_q;

  logic [63:0] req_ofs;
  logic [2:0]  in_off;
  logic        in_mis, in_flt, in_err;
  logic [63:0] resp_rdata;

  function automatic logic [63:0] size_mask(input logic [2:0] size);
    case (size)
      3'd0:    size_mask = 64'h0000_0000_0000_00FF;
      3'd1:    size_mask = 64'h0000_0000_0000_FFFF;
      3'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
      default: size_mask = '1;
    endcase
  endfunction

  // Checks are computed at capture and registered, so the flags only ever
  // reach the outputs through state-qualified registers.
  always_comb begin
    in_off  = i_ram_addr[2:0];
    req_ofs = i_ram_addr - BASE;
    case (i_ram_size)
      3'd0:    in_mis = 1'b0;
      3'd1:    in_mis = in_off[0];
      3'd2:    in_mis = |in_off[1:0];
      3'd3:    in_mis = |in_off;
      default: in_mis = 1'b1;
    endcase
    in_flt = (i_ram_addr < BASE) || ((req_ofs >> (ADDR_W + 3)) != 64'd0);
    in_err = in_mis | in_flt;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_ram_valid) begin
          if (in_err) begin
            state_d = RESP;
          end else if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = LAT_LOAD;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_wen_q  <= 1'b0;
      req_size_q <= '0;
      req_off_q  <= '0;
      mis_q      <= 1'b0;
      flt_q      <= 1'b0;
      rdata_q    <= '0;
      mem_idx_q  <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && i_ram_valid) begin
        req_wen_q  <= i_ram_wen;
        req_size_q <= i_ram_size;
        req_off_q  <= in_off;
        mis_q      <= in_mis;
        flt_q      <= in_flt & ~in_mis;
        if (!in_err) begin
          mem_idx_q <= req_ofs[ADDR_W+2:3];
          wmask_q   <= size_mask(i_ram_size) << {in_off, 3'b000};
          wdata_q   <= i_ram_wdata << {in_off, 3'b000};
        end
      end
      if (state_q == RESP) rdata_q <= resp_rdata;
    end
  end

  // RAM data arrives in RESP, so the load result is steered straight through
  // that cycle and held in rdata_q afterwards.
  always_comb begin
    resp_rdata = '0;
    if (!req_wen_q && !mis_q && !flt_q)
      resp_rdata = (i_mem_rdata >> {req_off_q, 3'b000}) & size_mask(req_size_q);
  end

  assign o_ram_ready = (state_q == RESP);
  assign o_ram_rdata = (state_q == RESP) ? resp_rdata : rdata_q;
  assign o_misalign  = (state_q == RESP) & mis_q;
  assign o_fault     = (state_q == RESP) & flt_q;
  assign o_mem_en    = (state_q == ACCESS);
  assign o_mem_wen   = (state_q == ACCESS) & req_wen_q;
  assign o_mem_idx   = mem_idx_q;
  assign o_mem_wmask = wmask_q;
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: instances with LATENCY 0 and 3 share one request stream;
// a byte-addressed memory model predicts every output of both, cycle by cycle.
module tb_dmem_bridge;
  localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;
  localparam int          ADDR_W = 20;
  localparam logic [63:0] SPAN   = 64'd1 << (ADDR_W + 3);
  localparam int          LAT1   = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        wen = 1'b0;
  logic [63:0] addr = '0;
  logic [2:0]  size = '0;
  logic [63:0] wdata = '0;

  logic              ready [2];
  logic [63:0]       rdata [2];
  logic              mis [2];
  logic              flt [2];
  logic              men [2];
  logic              mwen [2];
  logic [ADDR_W-1:0] midx [2];
  logic [63:0]       mmask [2];
  logic [63:0]       mwdat [2];
  logic [63:0]       mrd [2];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_bridge #(.BASE(BASE), .ADDR_W(ADDR_W), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .i_ram_valid(valid), .i_ram_wen(wen),
    .i_ram_addr(addr), .i_ram_size(size), .i_ram_wdata(wdata),
    .o_ram_ready(ready[0]), .o_ram_rdata(rdata[0]), .o_misalign(mis[0]),
    .o_fault(flt[0]), .o_mem_en(men[0]), .o_mem_wen(mwen[0]),
    .o_mem_idx(midx[0]), .o_mem_wmask(mmask[0]), .o_mem_wdata(mwdat[0]),
    .i_mem_rdata(mrd[0]));

  dmem_bridge #(.BASE(BASE), .ADDR_W(ADDR_W), .LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .i_ram_valid(valid), .i_ram_wen(wen),
    .i_ram_addr(addr), .i_ram_size(size), .i_ram_wdata(wdata),
    .o_ram_ready(ready[1]), .o_ram_rdata(rdata[1]), .o_misalign(mis[1]),
    .o_fault(flt[1]), .o_mem_en(men[1]), .o_mem_wen(mwen[1]),
    .o_mem_idx(midx[1]), .o_mem_wmask(mmask[1]), .o_mem_wdata(mwdat[1]),
    .i_mem_rdata(mrd[1]));

  // word RAM seen by each instance, keyed by instance and word index
  logic [63:0] ram [int unsigned];
  // reference byte memory, keyed by instance and byte address
  logic [7:0]  shadow [longint unsigned];

  function automatic int lat_of(input int i);
    return (i == 0) ? 0 : LAT1;
  endfunction

  function automatic longint unsigned skey(input int i, input logic [63:0] a);
    return a + (64'(i) << 48);
  endfunction

  function automatic logic [7:0] sread(input int i, input logic [63:0] a);
    longint unsigned k = skey(i, a);
    return shadow.exists(k) ? shadow[k] : 8'h00;
  endfunction

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void preload(input logic [63:0] a, input logic [63:0] v);
    for (int i = 0; i < 2; i++) begin
      ram[(32'(i) << 24) | 32'((a - BASE) >> 3)] = v;
      for (int b = 0; b < 8; b++) shadow[skey(i, a + 64'(b))] = v[8*b +: 8];
    end
  endfunction

  function automatic logic [63:0] ram_cycle(input int i);
    int unsigned k;
    logic [63:0] w;
    if (!men[i]) return {$urandom, $urandom};
    k = (32'(i) << 24) | 32'(midx[i]);
    w = ram.exists(k) ? ram[k] : 64'd0;
    if (mwen[i]) begin
      w = (w & ~mmask[i]) | (mwdat[i] & mmask[i]);
      ram[k] = w;
    end
    return w;
  endfunction

  always @(posedge clk) begin
    mrd[0] <= ram_cycle(0);
    mrd[1] <= ram_cycle(1);
  end

  // reference model: one outstanding request per instance, described by the
  // cycles in which its RAM strobe and ready pulse must appear
  int          p_mem [2];
  int          p_rdy [2];
  logic        p_wen [2];
  logic        p_mis [2];
  logic        p_flt [2];
  logic [63:0] p_addr [2];
  logic [63:0] p_wdata [2];
  logic [2:0]  p_size [2];
  logic [63:0] hold [2];
  bit          started = 1'b0;
  bit          rst_app = 1'b0;
  logic        e_en, e_rdy;
  logic [63:0] e_rd, e_mask;
  int          off, nb;

  initial begin
    for (int i = 0; i < 2; i++) begin
      p_mem[i] = -1;
      p_rdy[i] = -1;
      hold[i]  = '0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (started) begin
        e_en  = (cyc == p_mem[i]);
        e_rdy = (cyc == p_rdy[i]);
        if (e_rdy) begin
          e_rd = '0;
          if (!p_wen[i] && !p_mis[i] && !p_flt[i])
            for (int b = 0; b < (1 << p_size[i]); b++)
              e_rd |= 64'(sread(i, p_addr[i] + 64'(b))) << (8 * b);
          hold[i] = e_rd;
        end
        check($sformatf("dut%0d ready", i), 64'(ready[i]), 64'(e_rdy));
        check($sformatf("dut%0d misalign", i), 64'(mis[i]), 64'(e_rdy & p_mis[i]));
        check($sformatf("dut%0d fault", i), 64'(flt[i]), 64'(e_rdy & p_flt[i]));
        check($sformatf("dut%0d mem_en", i), 64'(men[i]), 64'(e_en));
        check($sformatf("dut%0d mem_wen", i), 64'(mwen[i]), 64'(e_en & p_wen[i]));
        check($sformatf("dut%0d rdata", i), rdata[i], hold[i]);
        if (e_en) begin
          off    = int'(p_addr[i][2:0]);
          nb     = 1 << p_size[i];
          e_mask = '0;
          for (int b = 0; b < nb; b++) e_mask[8*(off+b) +: 8] = 8'hFF;
          check($sformatf("dut%0d mem_idx", i), 64'(midx[i]), (p_addr[i] - BASE) >> 3);
          check($sformatf("dut%0d mem_wmask", i), mmask[i], e_mask);
          check($sformatf("dut%0d mem_wdata", i), mwdat[i], p_wdata[i] << (8 * off));
          if (p_wen[i])
            for (int b = 0; b < nb; b++) shadow[skey(i, p_addr[i] + 64'(b))] = p_wdata[i][8*b +: 8];
        end
        if (rst_app) begin
          check($sformatf("dut%0d reset idx", i), 64'(midx[i]), 64'd0);
          check($sformatf("dut%0d reset wmask", i), mmask[i], 64'd0);
          check($sformatf("dut%0d reset wdata", i), mwdat[i], 64'd0);
        end
      end
      if (!rst_n) begin
        p_mem[i] = -1;
        p_rdy[i] = -1;
        hold[i]  = '0;
      end else if (started && valid && cyc > p_rdy[i]) begin
        p_addr[i]  = addr;
        p_size[i]  = size;
        p_wen[i]   = wen;
        p_wdata[i] = wdata;
        p_mis[i]   = (size > 3'd3) || ((addr % (64'd1 << size)) != 64'd0);
        p_flt[i]   = !p_mis[i] && (addr < BASE || addr >= BASE + SPAN);
        if (p_mis[i] || p_flt[i]) begin
          p_mem[i] = -1;
          p_rdy[i] = cyc + 1;
        end else begin
          p_mem[i] = cyc + 1 + lat_of(i);
          p_rdy[i] = cyc + 2 + lat_of(i);
        end
      end
    end
    rst_app = !rst_n;
    if (!rst_n) started = 1'b1;
  end

  task automatic issue(input logic w, input logic [63:0] a, input logic [2:0] s,
                       input logic [63:0] d, output int t);
    @(posedge clk); #2;
    valid = 1'b1; wen = w; addr = a; size = s; wdata = d;
    t = cyc;
    @(posedge clk); #2;
    valid = 1'b0; wen = 1'($urandom); addr = {$urandom, $urandom};
    size = 3'($urandom); wdata = {$urandom, $urandom};
  endtask

  task automatic sample_at(input int c);
    int n = c - cyc;
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int t, t2;
    preload(64'h8000_0008, 64'h1122_3344_5566_7788);
    preload(64'h8000_0000, 64'hDEAD_BEEF_0000_0001);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    sample_at(cyc);
    for (int i = 0; i < 2; i++) begin
      check("reset ready", 64'(ready[i]), 64'd0);
      check("reset mem_en", 64'(men[i]), 64'd0);
      check("reset rdata", rdata[i], 64'd0);
    end

    // store byte, then load it back
    issue(1'b1, 64'h8000_0013, 3'd0, 64'h0000_0000_0000_00AB, t);
    sample_at(t + 1);
    check("sb mem_en T+1", 64'(men[0]), 64'd1);
    check("sb mem_wen", 64'(mwen[0]), 64'd1);
    check("sb idx", 64'(midx[0]), 64'd2);
    check("sb wmask", mmask[0], 64'h0000_0000_FF00_0000);
    check("sb wdata", mwdat[0], 64'h0000_0000_AB00_0000);
    sample_at(t + 2);
    check("sb ready T+2", 64'(ready[0]), 64'd1);
    sample_at(t + 5);
    check("sb ready lat3", 64'(ready[1]), 64'd1);
    issue(1'b0, 64'h8000_0013, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, t);
    sample_at(t + 2);
    check("lb rdata", rdata[0], 64'h0000_0000_0000_00AB);
    sample_at(t + 5);
    check("lb rdata lat3", rdata[1], 64'h0000_0000_0000_00AB);

    // load double with wait states
    issue(1'b0, 64'h8000_0008, 3'd3, 64'd0, t);
    sample_at(t + 3);
    check("ld mem_en T+3", 64'(men[1]), 64'd0);
    sample_at(t + 4);
    check("ld mem_en T+4", 64'(men[1]), 64'd1);
    sample_at(t + 5);
    check("ld ready T+5", 64'(ready[1]), 64'd1);
    check("ld rdata", rdata[1], 64'h1122_3344_5566_7788);

    // word load from upper half
    issue(1'b0, 64'h8000_0004, 3'd2, 64'd0, t);
    sample_at(t + 2);
    check("lw rdata", rdata[0], 64'h0000_0000_DEAD_BEEF);
    sample_at(t + 5);

    // misaligned half, then out-of-range double
    issue(1'b0, 64'h8000_0001, 3'd1, 64'd0, t);
    sample_at(t + 1);
    check("mis ready", 64'(ready[0]), 64'd1);
    check("mis flag", 64'(mis[0]), 64'd1);
    check("mis flag lat3", 64'(mis[1]), 64'd1);
    check("mis no fault", 64'(flt[0]), 64'd0);
    issue(1'b0, 64'h7FFF_FFF8, 3'd3, 64'd0, t);
    sample_at(t + 1);
    check("flt ready", 64'(ready[1]), 64'd1);
    check("flt flag", 64'(flt[0]), 64'd1);
    check("flt no misalign", 64'(mis[0]), 64'd0);

    // extra valid pulses while busy must be ignored
    issue(1'b0, 64'h8000_0008, 3'd3, 64'd0, t);
    valid = 1'b1; wen = 1'b1; addr = 64'h8000_0008; size = 3'd3; wdata = '1;
    @(posedge clk); #2;
    addr = 64'h8000_0000;
    @(posedge clk); #2;
    valid = 1'b0;
    sample_at(t + 3);
    check("busy rdata held", rdata[0], 64'h1122_3344_5566_7788);
    sample_at(t + 5);
    check("busy rdata lat3", rdata[1], 64'h1122_3344_5566_7788);
    issue(1'b0, 64'h8000_0008, 3'd3, 64'd0, t);
    sample_at(t + 2);
    check("busy word intact", rdata[0], 64'h1122_3344_5566_7788);
    sample_at(t + 5);

    // reset during WAIT aborts the transaction
    issue(1'b0, 64'h8000_0000, 3'd3, 64'd0, t);
    rst_n = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    sample_at(t + 2);
    check("rst ready", 64'(ready[0]), 64'd0);
    check("rst rdata", rdata[1], 64'd0);
    check("rst mem_en", 64'(men[1]), 64'd0);
    sample_at(t + 5);
    check("rst no ready lat3", 64'(ready[1]), 64'd0);

    // back-to-back sh / lh at minimum spacing
    issue(1'b1, 64'h8000_0006, 3'd1, 64'h0000_0000_0000_BEEF, t);
    @(posedge clk); #2;
    issue(1'b0, 64'h8000_0006, 3'd1, 64'd0, t2);
    sample_at(t2 + 2);
    check("b2b ready", 64'(ready[0]), 64'd1);
    check("b2b rdata", rdata[0], 64'h0000_0000_0000_BEEF);
    sample_at(t2 + 4);
    issue(1'b0, 64'h8000_0006, 3'd1, 64'd0, t);
    sample_at(t + 5);
    check("b2b rdata lat3", rdata[1], 64'h0000_0000_0000_BEEF);

    // random traffic, occasional resets
    repeat (800) begin
      @(posedge clk); #2;
      valid = ($urandom_range(0, 2) == 0);
      wen   = 1'($urandom);
      size  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       addr = BASE - 64'($urandom_range(1, 16));
        1:       addr = BASE + SPAN - 64'd16 + 64'($urandom_range(0, 31));
        default: addr = BASE + 64'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 1) == 1) addr = addr & ~64'd7;
      wdata = {$urandom, $urandom};
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk); #2;
    valid = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
